// File: rtl/bcast_fifo_pkg.sv
// Shared constants, occupancy helper and reader-select type for the broadcast FIFO.
package bcast_fifo_pkg;

   localparam int ERR_OVF   = 0;
   localparam int ERR_UNF_A = 1;
   localparam int ERR_UNF_B = 2;

   typedef enum logic {
      RD_A = 1'b0,
      RD_B = 1'b1
   } rd_sel_t;

   // Callers truncate the result to pointer width, which yields the modulo occupancy.
   function automatic logic [31:0] ptr_diff(input logic [31:0] wr, input logic [31:0] rd);
      return wr - rd;
   endfunction

endpackage

// File: rtl/bcast_fifo_mem.sv
// DEPTH x D_WIDTH register array: one synchronous write port, two asynchronous read ports, no reset.
module bcast_fifo_mem #(
   parameter int D_WIDTH = 6,
   parameter int A_WIDTH = 3
) (
   input  logic               clk,
   input  logic               we,
   input  logic [A_WIDTH-1:0] waddr,
   input  logic [D_WIDTH-1:0] wdata,
   input  logic [A_WIDTH-1:0] raddr_a,
   input  logic [A_WIDTH-1:0] raddr_b,
   output logic [D_WIDTH-1:0] rdata_a,
   output logic [D_WIDTH-1:0] rdata_b
);

   localparam int DEPTH = 1 << A_WIDTH;

   logic [D_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/bcast_fifo_ctrl.sv
// One-writer / two-reader broadcast FIFO controller with show-ahead outputs per reader.
// Optional sticky overflow/underflow flags on port err when BCAST_FIFO_ERR_EN is defined.
module bcast_fifo_ctrl
   import bcast_fifo_pkg::*;
#(
   parameter int D_WIDTH = 6,
   parameter int A_WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] up_data,
   input  logic               push,
   output logic               full,
   output logic [D_WIDTH-1:0] down_data_a,
   input  logic               pop_a,
   output logic               empty_a,
   output logic [A_WIDTH:0]   count_a,
   output logic [D_WIDTH-1:0] down_data_b,
   input  logic               pop_b,
   output logic               empty_b,
   output logic [A_WIDTH:0]   count_b
`ifdef BCAST_FIFO_ERR_EN
   ,
   output logic [2:0]         err
`endif
);

   localparam int PW = A_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH_C = PW'(1 << A_WIDTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr [2];
   logic [D_WIDTH-1:0] rdata_a;
   logic [D_WIDTH-1:0] rdata_b;
   logic               push_ok;
   logic               pop_ok_a;
   logic               pop_ok_b;

   // Flags derive from registered pointers only, so same-cycle requests never bypass.
   assign count_a = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr[RD_A])));
   assign count_b = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr[RD_B])));
   assign empty_a = (count_a == '0);
   assign empty_b = (count_b == '0);
   assign full    = (count_a == DEPTH_C) || (count_b == DEPTH_C);

   assign push_ok  = push  && !full;
   assign pop_ok_a = pop_a && !empty_a;
   assign pop_ok_b = pop_b && !empty_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr[RD_A] <= '0;
         rd_ptr[RD_B] <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok_a) begin
            rd_ptr[RD_A] <= rd_ptr[RD_A] + PTR_ONE;
         end
         if (pop_ok_b) begin
            rd_ptr[RD_B] <= rd_ptr[RD_B] + PTR_ONE;
         end
      end
   end

   bcast_fifo_mem #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH)
   ) u_mem (
      .clk     (clk),
      .we      (push_ok),
      .waddr   (wr_ptr[A_WIDTH-1:0]),
      .wdata   (up_data),
      .raddr_a (rd_ptr[RD_A][A_WIDTH-1:0]),
      .raddr_b (rd_ptr[RD_B][A_WIDTH-1:0]),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b)
   );

   // Memory is not reset, so stale contents are masked while a reader is empty.
   assign down_data_a = empty_a ? '0 : rdata_a;
   assign down_data_b = empty_b ? '0 : rdata_b;

`ifdef BCAST_FIFO_ERR_EN
   logic [2:0] err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         if (push && full) begin
            err_q[ERR_OVF] <= 1'b1;
         end
         if (pop_a && empty_a) begin
            err_q[ERR_UNF_A] <= 1'b1;
         end
         if (pop_b && empty_b) begin
            err_q[ERR_UNF_B] <= 1'b1;
         end
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_bcast_fifo_ctrl.sv
// Directed self-checking bench for bcast_fifo_ctrl (either build of BCAST_FIFO_ERR_EN).
module tb_bcast_fifo_ctrl;

   logic       clk;
   logic       rst;
   logic [5:0] up_data;
   logic       push;
   logic       full;
   logic [5:0] down_data_a;
   logic       pop_a;
   logic       empty_a;
   logic [3:0] count_a;
   logic [5:0] down_data_b;
   logic       pop_b;
   logic       empty_b;
   logic [3:0] count_b;
`ifdef BCAST_FIFO_ERR_EN
   logic [2:0] err;
`endif

   int total;
   int bad;

   bcast_fifo_ctrl #(.D_WIDTH(6), .A_WIDTH(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .up_data     (up_data),
      .push        (push),
      .full        (full),
      .down_data_a (down_data_a),
      .pop_a       (pop_a),
      .empty_a     (empty_a),
      .count_a     (count_a),
      .down_data_b (down_data_b),
      .pop_b       (pop_b),
      .empty_b     (empty_b),
      .count_b     (count_b)
`ifdef BCAST_FIFO_ERR_EN
      ,
      .err         (err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // One clock of stimulus; outputs are stable 1 time unit after the edge.
   task automatic do_cycle(input logic p, input logic [5:0] d, input logic a, input logic b);
      push    = p;
      up_data = d;
      pop_a   = a;
      pop_b   = b;
      @(posedge clk);
      #1;
      push  = 1'b0;
      pop_a = 1'b0;
      pop_b = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_cycle(1'b1, 6'h05, 1'b0, 1'b0);
      do_cycle(1'b1, 6'h06, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL reset_empty_a got %b want 1", empty_a); end
      total++; if (empty_b !== 1'b1) begin bad++; $display("FAIL reset_empty_b got %b want 1", empty_b); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got %b want 0", full); end
      total++; if (count_a !== 4'd0) begin bad++; $display("FAIL reset_count_a got %0d want 0", count_a); end
      total++; if (count_b !== 4'd0) begin bad++; $display("FAIL reset_count_b got %0d want 0", count_b); end
      total++; if (down_data_a !== 6'h00) begin bad++; $display("FAIL reset_data_a got %h want 00", down_data_a); end
      total++; if (down_data_b !== 6'h00) begin bad++; $display("FAIL reset_data_b got %h want 00", down_data_b); end
`ifdef BCAST_FIFO_ERR_EN
      total++; if (err !== 3'b000) begin bad++; $display("FAIL reset_err got %b want 000", err); end
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      apply_reset();
      do_cycle(1'b1, 6'h11, 1'b0, 1'b0);
      total++; if (down_data_a !== 6'h11 || empty_a !== 1'b0) begin bad++; $display("FAIL basic_latency got %h/%b want 11/0", down_data_a, empty_a); end
      do_cycle(1'b1, 6'h22, 1'b0, 1'b0);
      do_cycle(1'b1, 6'h33, 1'b0, 1'b0);
      do_cycle(1'b0, 6'h00, 1'b1, 1'b0);
      total++; if (down_data_a !== 6'h22) begin bad++; $display("FAIL basic_data_a got %h want 22", down_data_a); end
      total++; if (count_a !== 4'd2) begin bad++; $display("FAIL basic_count_a got %0d want 2", count_a); end
      total++; if (down_data_b !== 6'h11) begin bad++; $display("FAIL basic_data_b got %h want 11", down_data_b); end
      total++; if (count_b !== 4'd3) begin bad++; $display("FAIL basic_count_b got %0d want 3", count_b); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL basic_full got %b want 0", full); end
   endtask

   // Fill to DEPTH, drop an overflow push, then drain A while B still holds everything.
   task automatic test_fill_skew();
      apply_reset();
      for (int i = 1; i <= 8; i++) begin
         do_cycle(1'b1, 6'(i), 1'b0, 1'b0);
         if (i == 7) begin
            total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full7 got %b want 0", full); end
         end
      end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full8 got %b want 1", full); end
      do_cycle(1'b1, 6'h3F, 1'b0, 1'b0);
      total++; if (count_a !== 4'd8 || count_b !== 4'd8) begin bad++; $display("FAIL fill_drop_counts got %0d/%0d want 8/8", count_a, count_b); end
      total++; if (down_data_a !== 6'h01) begin bad++; $display("FAIL fill_drop_head got %h want 01", down_data_a); end
`ifdef BCAST_FIFO_ERR_EN
      total++; if (err !== 3'b001) begin bad++; $display("FAIL fill_err got %b want 001", err); end
`endif
      for (int i = 1; i <= 8; i++) begin
         total++; if (down_data_a !== 6'(i)) begin bad++; $display("FAIL skew_order_a got %h want %h", down_data_a, 6'(i)); end
         do_cycle(1'b0, 6'h00, 1'b1, 1'b0);
      end
      total++; if (empty_a !== 1'b1 || count_a !== 4'd0) begin bad++; $display("FAIL skew_a_drained got %b/%0d want 1/0", empty_a, count_a); end
      total++; if (full !== 1'b1 || count_b !== 4'd8) begin bad++; $display("FAIL skew_full_b got %b/%0d want 1/8", full, count_b); end
      do_cycle(1'b1, 6'h15, 1'b0, 1'b1);
      total++; if (full !== 1'b0 || count_b !== 4'd7 || count_a !== 4'd0) begin bad++; $display("FAIL skew_pop_b got full=%b cb=%0d ca=%0d want 0/7/0", full, count_b, count_a); end
      do_cycle(1'b1, 6'h2A, 1'b0, 1'b0);
      total++; if (count_a !== 4'd1 || count_b !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL skew_push got ca=%0d cb=%0d full=%b want 1/8/1", count_a, count_b, full); end
      total++; if (down_data_a !== 6'h2A || down_data_b !== 6'h02) begin bad++; $display("FAIL skew_heads got %h/%h want 2a/02", down_data_a, down_data_b); end
`ifdef BCAST_FIFO_ERR_EN
      total++; if (err !== 3'b001) begin bad++; $display("FAIL skew_err got %b want 001", err); end
`endif
   endtask

   task automatic test_pop_empty();
      apply_reset();
      do_cycle(1'b0, 6'h00, 1'b1, 1'b0);
      total++; if (count_a !== 4'd0 || empty_a !== 1'b1) begin bad++; $display("FAIL pop_empty_state got %0d/%b want 0/1", count_a, empty_a); end
`ifdef BCAST_FIFO_ERR_EN
      total++; if (err !== 3'b010) begin bad++; $display("FAIL pop_empty_err got %b want 010", err); end
`endif
      // Push plus pop into an empty FIFO: the pop must be ignored.
      do_cycle(1'b1, 6'h15, 1'b1, 1'b0);
      total++; if (count_a !== 4'd1 || down_data_a !== 6'h15) begin bad++; $display("FAIL nobypass got %0d/%h want 1/15", count_a, down_data_a); end
      do_cycle(1'b0, 6'h00, 1'b0, 1'b0);
      do_cycle(1'b0, 6'h00, 1'b0, 1'b0);
`ifdef BCAST_FIFO_ERR_EN
      total++; if (err !== 3'b010) begin bad++; $display("FAIL err_sticky got %b want 010", err); end
      apply_reset();
      total++; if (err !== 3'b000) begin bad++; $display("FAIL err_clear got %b want 000", err); end
`endif
   endtask

   task automatic test_wrap();
      logic [5:0] q[$];
      logic [5:0] w;
      apply_reset();
      w = 6'h03;
      q.push_back(w);
      do_cycle(1'b1, w, 1'b0, 1'b0);
      for (int i = 1; i < 20; i++) begin
         total++; if (down_data_a !== q[0] || down_data_b !== q[0]) begin bad++; $display("FAIL wrap_data[%0d] got %h/%h want %h", i, down_data_a, down_data_b, q[0]); end
         w = 6'((i * 7 + 3) & 63);
         do_cycle(1'b1, w, 1'b1, 1'b1);
         void'(q.pop_front());
         q.push_back(w);
         total++; if (count_a !== 4'd1 || count_b !== 4'd1) begin bad++; $display("FAIL wrap_count[%0d] got %0d/%0d want 1/1", i, count_a, count_b); end
      end
      total++; if (down_data_a !== q[0] || down_data_b !== q[0]) begin bad++; $display("FAIL wrap_final got %h/%h want %h", down_data_a, down_data_b, q[0]); end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      push    = 1'b0;
      pop_a   = 1'b0;
      pop_b   = 1'b0;
      up_data = 6'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_basic();
      test_fill_skew();
      test_pop_empty();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
